// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared pipeline definitions (opcodes, aluOp encodings, control word layout).
package id_stage_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam int CTRL_W = 10;
  // Field order fixes the id_ctrl bit positions: reg_dst is bit 9, alu_op is bits 2:0.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c.reg_dst    = op == OP_RTYPE;
    c.alu_src    = op inside {OP_LW, OP_SW, OP_ADDI};
    c.mem_to_reg = op == OP_LW;
    c.reg_write  = op inside {OP_RTYPE, OP_LW, OP_ADDI};
    c.mem_read   = op == OP_LW;
    c.mem_write  = op == OP_SW;
    c.branch     = op == OP_BEQ;
    c.alu_op     = op == OP_RTYPE ? ALU_FUNCT : op == OP_BEQ ? ALU_SUB : ALU_ADD;
    return c;
  endfunction
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch/EX/MEM/WB side signals into the decode stage and its decoded outputs.
interface id_stage_if;
  import id_stage_pkg::*;
  logic [31:0]       if_pc_4;
  logic [31:0]       if_instruction;
  logic              mem_shouldBranch;
  logic              ex_memRead;
  logic [4:0]        ex_rt;
  logic              wb_regWrite;
  logic [4:0]        wb_writeReg;
  logic [31:0]       wb_writeData;
  logic              id_stall;
  logic [31:0]       id_pc_4;
  logic [31:0]       id_rsData;
  logic [31:0]       id_rtData;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  modport master (
    output if_pc_4, if_instruction, mem_shouldBranch, ex_memRead, ex_rt,
           wb_regWrite, wb_writeReg, wb_writeData,
    input  id_stall, id_pc_4, id_rsData, id_rtData, id_imm, id_rs, id_rt, id_rd, id_ctrl
  );
  modport slave (
    input  if_pc_4, if_instruction, mem_shouldBranch, ex_memRead, ex_rt,
           wb_regWrite, wb_writeReg, wb_writeData,
    output id_stall, id_pc_4, id_rsData, id_rtData, id_imm, id_rs, id_rt, id_rd, id_ctrl
  );
endinterface

// File: rtl/id_stage_regfile.sv
// RegisterFile: 32x32 registers, two read ports with write-through bypass, one write port; $0 is hardwired to zero.
module RegisterFile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] regs [32];
  logic        wr_en;
  assign wr_en = we && !reset && waddr != '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (wr_en) regs[waddr] <= wdata;
  // $0 is never written, so its storage stays zero and needs no read special case.
  assign rdata_a = wr_en && waddr == raddr_a ? wdata : regs[raddr_a];
  assign rdata_b = wr_en && waddr == raddr_b ? wdata : regs[raddr_b];
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID pipeline register, instruction decode, register file read and load-use hazard detection.
module id_stage
  import id_stage_pkg::*;
(
  input logic   clock,
  input logic   reset,
  id_stage_if.slave bus
);
  logic [31:0] pc_q, instr_q, rs_data, rt_data;
  logic [4:0]  rs, rt;
  logic        stall;
  ctrl_t       ctrl;
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign stall = bus.ex_memRead && bus.ex_rt != '0 && (bus.ex_rt == rs || bus.ex_rt == rt);
  // Flush beats stall so a taken branch also releases a pending load-use hold.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (bus.mem_shouldBranch) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (!stall) begin
      pc_q    <= bus.if_pc_4;
      instr_q <= bus.if_instruction;
    end
  RegisterFile u_rf (
    .clock   (clock),
    .reset   (reset),
    .we      (bus.wb_regWrite),
    .waddr   (bus.wb_writeReg),
    .wdata   (bus.wb_writeData),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );
  assign ctrl          = decode(instr_q[31:26]);
  assign bus.id_stall  = stall;
  assign bus.id_pc_4   = pc_q;
  assign bus.id_rsData = rs_data;
  assign bus.id_rtData = rt_data;
  assign bus.id_imm    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign bus.id_rs     = rs;
  assign bus.id_rt     = rt;
  assign bus.id_rd     = instr_q[15:11];
  assign bus.id_ctrl   = stall ? '0 : ctrl;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a behavioural pipeline model.
module tb_id_stage;
  logic clock = 0;
  logic reset = 1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  id_stage_if bus();
  id_stage dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ins;
  logic        m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] m_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 10'b1001000010;
      6'h23:   return 10'b0111100000;
      6'h2B:   return 10'b0100010000;
      6'h04:   return 10'b0000001001;
      6'h08:   return 10'b0101000000;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic m_stall();
    return bus.ex_memRead && bus.ex_rt != 0 && (bus.ex_rt == m_ins[25:21] || bus.ex_rt == m_ins[20:16]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (!reset && bus.wb_regWrite && bus.wb_writeReg != 0 && bus.wb_writeReg == idx) return bus.wb_writeData;
    return m_regs[idx];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc = 0;
      m_ins = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
    end else begin
      m_st = m_stall();
      if (bus.wb_regWrite && bus.wb_writeReg != 0) m_regs[bus.wb_writeReg] = bus.wb_writeData;
      if (bus.mem_shouldBranch) begin
        m_pc = 0;
        m_ins = 0;
      end else if (!m_st) begin
        m_pc = bus.if_pc_4;
        m_ins = bus.if_instruction;
      end
    end
  end

  always @(negedge clock) if (chk_en) begin
    chk("stall", bus.id_stall, m_stall());
    chk("pc_4", bus.id_pc_4, m_pc);
    chk("rs", bus.id_rs, m_ins[25:21]);
    chk("rt", bus.id_rt, m_ins[20:16]);
    chk("rd", bus.id_rd, m_ins[15:11]);
    chk("imm", bus.id_imm, {{16{m_ins[15]}}, m_ins[15:0]});
    chk("rsData", bus.id_rsData, m_read(m_ins[25:21]));
    chk("rtData", bus.id_rtData, m_read(m_ins[20:16]));
    chk("ctrl", bus.id_ctrl, m_stall() ? 10'b0 : m_ctrl(m_ins[31:26]));
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  logic [5:0] ops [6];
  logic [5:0] op;
  logic [4:0] pick [4];

  initial begin
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    bus.if_pc_4 = 0;
    bus.if_instruction = 0;
    bus.mem_shouldBranch = 0;
    bus.ex_memRead = 0;
    bus.ex_rt = 0;
    bus.wb_regWrite = 0;
    bus.wb_writeReg = 0;
    bus.wb_writeData = 0;
    tick();
    reset = 0;
    chk_en = 1;
    chk("rst_ctrl", bus.id_ctrl, 32'h242);
    chk("rst_pc", bus.id_pc_4, 0);
    chk("rst_rsData", bus.id_rsData, 0);
    chk("rst_rtData", bus.id_rtData, 0);
    chk("rst_stall", bus.id_stall, 0);
    bus.if_instruction = 32'h8C220004;
    bus.if_pc_4 = 4;
    tick();
    chk("lw_ctrl", bus.id_ctrl, 32'h1E0);
    chk("lw_rs", bus.id_rs, 1);
    chk("lw_rt", bus.id_rt, 2);
    chk("lw_imm", bus.id_imm, 4);
    chk("lw_pc", bus.id_pc_4, 4);
    bus.if_instruction = 32'h00A03020;
    bus.if_pc_4 = 8;
    tick();
    bus.wb_regWrite = 1;
    bus.wb_writeReg = 5;
    bus.wb_writeData = 32'hDEADBEEF;
    #1;
    chk("bypass_rs", bus.id_rsData, 32'hDEADBEEF);
    tick();
    bus.wb_regWrite = 0;
    #1;
    chk("stored_rs", bus.id_rsData, 32'hDEADBEEF);
    bus.wb_regWrite = 1;
    bus.wb_writeReg = 0;
    bus.wb_writeData = 32'h1234;
    #1;
    chk("r0_bypass", bus.id_rtData, 0);
    tick();
    bus.wb_regWrite = 0;
    #1;
    chk("r0_read", bus.id_rtData, 0);
    bus.if_instruction = 32'h00612020;
    bus.if_pc_4 = 12;
    tick();
    bus.ex_memRead = 1;
    bus.ex_rt = 3;
    bus.if_instruction = 32'h8C220004;
    bus.if_pc_4 = 16;
    #1;
    chk("hz_stall", bus.id_stall, 1);
    chk("hz_ctrl", bus.id_ctrl, 0);
    tick();
    chk("hz_hold_rs", bus.id_rs, 3);
    chk("hz_hold_rd", bus.id_rd, 4);
    chk("hz_hold_pc", bus.id_pc_4, 12);
    bus.ex_memRead = 0;
    #1;
    chk("hz_clear", bus.id_stall, 0);
    chk("hz_clear_ctrl", bus.id_ctrl, 32'h242);
    bus.ex_memRead = 1;
    #1;
    chk("hz_again", bus.id_stall, 1);
    bus.mem_shouldBranch = 1;
    tick();
    chk("fl_pc", bus.id_pc_4, 0);
    chk("fl_rs", bus.id_rs, 0);
    chk("fl_rd", bus.id_rd, 0);
    chk("fl_stall", bus.id_stall, 0);
    chk("fl_ctrl", bus.id_ctrl, 32'h242);
    bus.mem_shouldBranch = 0;
    bus.ex_memRead = 0;
    bus.if_instruction = 32'h1022FFFC;
    bus.if_pc_4 = 20;
    tick();
    chk("beq_imm", bus.id_imm, 32'hFFFFFFFC);
    chk("beq_ctrl", bus.id_ctrl, 32'h009);
    for (int n = 0; n < 3000; n++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 6'h3F) op = 6'($urandom);
      bus.if_instruction = {op, 26'($urandom)};
      bus.if_pc_4 = $urandom;
      bus.mem_shouldBranch = $urandom_range(0, 9) == 0;
      bus.ex_memRead = $urandom_range(0, 2) == 0;
      pick = '{m_ins[25:21], m_ins[20:16], 5'($urandom), 5'd0};
      bus.ex_rt = pick[$urandom_range(0, 3)];
      bus.wb_regWrite = $urandom_range(0, 1);
      bus.wb_writeReg = $urandom_range(0, 3) == 0 ? m_ins[25:21] : 5'($urandom);
      bus.wb_writeData = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
